// File: rtl/stream_hdr_insert.sv
// Prepends an H-byte header (0..DATA_BYTE_WD) to a byte-keep packet stream, repacking densely.
// Define STREAM_INSERT_OUT_REG_EN to register the output through a two-entry skid buffer.
module stream_hdr_insert #(
    parameter int unsigned DATA_WD      = 32,
    parameter int unsigned DATA_BYTE_WD = DATA_WD / 8,
    parameter int unsigned BYTE_CNT_WD  = $clog2(DATA_BYTE_WD) + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_in,
    output logic                    ready_in,
    input  logic [DATA_WD-1:0]      data_in,
    input  logic [DATA_BYTE_WD-1:0] keep_in,
    input  logic                    last_in,
    input  logic                    valid_insert,
    output logic                    ready_insert,
    input  logic [DATA_WD-1:0]      data_insert,
    input  logic [BYTE_CNT_WD-1:0]  byte_insert_cnt,
    output logic                    valid_out,
    input  logic                    ready_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
    output logic                    last_out
);

    localparam int unsigned SH_WD  = $clog2(DATA_WD) + 1;
    localparam int unsigned SUM_WD = BYTE_CNT_WD + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BODY = 2'd1,
        TAIL = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [DATA_WD-1:0]      r_carry;
    logic [DATA_WD-1:0]      w_carry_nxt;
    logic [BYTE_CNT_WD-1:0]  r_cnt;
    logic [BYTE_CNT_WD-1:0]  w_cnt_nxt;

    logic [BYTE_CNT_WD-1:0]  w_h;
    logic [BYTE_CNT_WD-1:0]  w_hdr_gap;
    logic [BYTE_CNT_WD-1:0]  w_carry_gap;
    logic [SH_WD-1:0]        w_sh_hdr;
    logic [SH_WD-1:0]        w_sh_c;
    logic [SH_WD-1:0]        w_sh_rem;
    logic [BYTE_CNT_WD-1:0]  w_v;
    logic [SUM_WD-1:0]       w_sum;
    logic                    w_fits;
    logic [DATA_WD-1:0]      w_din_m;

    logic                    w_c_valid;
    logic                    w_c_ready;
    logic [DATA_WD-1:0]      w_c_data;
    logic [DATA_BYTE_WD-1:0] w_c_keep;
    logic                    w_c_last;
    logic                    w_ready_in;
    logic                    w_ready_ins;

    // MSB-contiguous keep with cnt bytes set
    function automatic logic [DATA_BYTE_WD-1:0] f_keep(input logic [SUM_WD-1:0] cnt);
        logic [DATA_BYTE_WD-1:0] k;
        k = '0;
        for (int i = 0; i < int'(DATA_BYTE_WD); i++) begin
            if (SUM_WD'(i) < cnt) k[int'(DATA_BYTE_WD) - 1 - i] = 1'b1;
        end
        return k;
    endfunction

    // Expand a byte keep into a bit mask
    function automatic logic [DATA_WD-1:0] f_bytes(input logic [DATA_BYTE_WD-1:0] k);
        logic [DATA_WD-1:0] m;
        m = '0;
        for (int i = 0; i < int'(DATA_BYTE_WD); i++) begin
            m[8*i +: 8] = {8{k[i]}};
        end
        return m;
    endfunction

    assign w_h = (byte_insert_cnt > BYTE_CNT_WD'(DATA_BYTE_WD)) ? BYTE_CNT_WD'(DATA_BYTE_WD)
                                                                : byte_insert_cnt;
    assign w_hdr_gap   = BYTE_CNT_WD'(DATA_BYTE_WD) - w_h;
    assign w_carry_gap = BYTE_CNT_WD'(DATA_BYTE_WD) - r_cnt;
    assign w_sh_hdr    = SH_WD'({w_hdr_gap, 3'b000});
    assign w_sh_c      = SH_WD'({r_cnt, 3'b000});
    assign w_sh_rem    = SH_WD'({w_carry_gap, 3'b000});
    // Invalid input bytes are zeroed up front so every shifted copy is zero-filled
    assign w_din_m     = data_in & f_bytes(keep_in);

    always_comb begin
        w_v = '0;
        for (int i = 0; i < int'(DATA_BYTE_WD); i++) begin
            w_v = w_v + BYTE_CNT_WD'(keep_in[i]);
        end
    end

    assign w_sum  = SUM_WD'(r_cnt) + SUM_WD'(w_v);
    assign w_fits = (w_sum <= SUM_WD'(DATA_BYTE_WD));

    // State and carry registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_carry <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_carry <= w_carry_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state, carry update and core output beat
    always_comb begin
        w_state_nxt = r_state;
        w_carry_nxt = r_carry;
        w_cnt_nxt   = r_cnt;
        w_c_valid   = 1'b0;
        w_c_data    = '0;
        w_c_keep    = '0;
        w_c_last    = 1'b0;
        w_ready_in  = 1'b0;
        w_ready_ins = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_ready_ins = 1'b1;
                if (valid_insert) begin
                    w_carry_nxt = data_insert << w_sh_hdr;
                    w_cnt_nxt   = w_h;
                    w_state_nxt = BODY;
                end
            end
            BODY: begin
                w_c_valid  = valid_in;
                w_ready_in = w_c_ready;
                w_c_data   = r_carry | (w_din_m >> w_sh_c);
                w_c_keep   = '1;
                if (last_in && w_fits) begin
                    w_c_keep = f_keep(w_sum);
                    w_c_last = 1'b1;
                end
                if (valid_in && w_c_ready) begin
                    if (last_in && w_fits) begin
                        w_carry_nxt = '0;
                        w_cnt_nxt   = '0;
                        w_state_nxt = IDLE;
                    end else begin
                        w_carry_nxt = w_din_m << w_sh_rem;
                        if (last_in) begin
                            w_cnt_nxt   = BYTE_CNT_WD'(w_sum - SUM_WD'(DATA_BYTE_WD));
                            w_state_nxt = TAIL;
                        end
                    end
                end
            end
            TAIL: begin
                w_c_valid = 1'b1;
                w_c_last  = 1'b1;
                w_c_data  = r_carry;
                w_c_keep  = f_keep(SUM_WD'(r_cnt));
                if (w_c_ready) begin
                    w_carry_nxt = '0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        w_c_data = w_c_data & f_bytes(w_c_keep);
    end

    assign ready_in     = w_ready_in;
    assign ready_insert = w_ready_ins & ~rst;

`ifdef STREAM_INSERT_OUT_REG_EN
    localparam int unsigned ENT_WD = DATA_WD + DATA_BYTE_WD + 1;

    logic [ENT_WD-1:0] r_buf [2];
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [1:0]        r_fill;
    logic              w_push;
    logic              w_pop;

    // Ready toward the core depends only on fill level, cutting the ready_out path
    assign w_c_ready = (r_fill != 2'd2);
    assign w_push    = w_c_valid & w_c_ready;
    assign w_pop     = (r_fill != 2'd0) & ready_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buf[0] <= '0;
            r_buf[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_fill   <= 2'd0;
        end else begin
            if (w_push) begin
                r_buf[r_wr_ptr] <= {w_c_data, w_c_keep, w_c_last};
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) r_rd_ptr <= ~r_rd_ptr;
            case ({w_push, w_pop})
                2'b10:   r_fill <= r_fill + 2'd1;
                2'b01:   r_fill <= r_fill - 2'd1;
                default: r_fill <= r_fill;
            endcase
        end
    end

    assign valid_out                      = (r_fill != 2'd0);
    assign {data_out, keep_out, last_out} = r_buf[r_rd_ptr];
`else
    assign w_c_ready = ready_out;
    assign valid_out = w_c_valid;
    assign data_out  = w_c_data;
    assign keep_out  = w_c_keep;
    assign last_out  = w_c_last;
`endif

endmodule

// File: tb/tb_stream_hdr_insert.sv
// Bench for stream_hdr_insert: directed vector table, reset corner cases and a
// randomized run against a byte-queue reference model with output-stall stability checks.
module tb_stream_hdr_insert;

    localparam int TMO = 200;

    logic        clk;
    logic        rst;
    logic        valid_in;
    logic        ready_in;
    logic [31:0] data_in;
    logic [3:0]  keep_in;
    logic        last_in;
    logic        valid_insert;
    logic        ready_insert;
    logic [31:0] data_insert;
    logic [2:0]  byte_insert_cnt;
    logic        valid_out;
    logic        ready_out;
    logic [31:0] data_out;
    logic [3:0]  keep_out;
    logic        last_out;

    stream_hdr_insert dut (
        .clk             (clk),
        .rst             (rst),
        .valid_in        (valid_in),
        .ready_in        (ready_in),
        .data_in         (data_in),
        .keep_in         (keep_in),
        .last_in         (last_in),
        .valid_insert    (valid_insert),
        .ready_insert    (ready_insert),
        .data_insert     (data_insert),
        .byte_insert_cnt (byte_insert_cnt),
        .valid_out       (valid_out),
        .ready_out       (ready_out),
        .data_out        (data_out),
        .keep_out        (keep_out),
        .last_out        (last_out)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } exp_t;

    typedef struct packed {
        logic [2:0]       h;
        logic [31:0]      hdr;
        logic [2:0]       nin;
        logic [3:0][31:0] din;
        logic [3:0]       kin;
        logic [2:0]       nout;
        logic [3:0][31:0] dout;
        logic [3:0]       kout;
    } vec_t;

    exp_t        exp_q[$];
    vec_t        vecs[6];
    int          checks;
    int          failures;
    bit          rand_ready;
    bit          stall_prev;
    logic [31:0] s_data;
    logic [3:0]  s_keep;
    logic        s_last;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #800000;
        $display("FAIL watchdog simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // Output-side ready generator
    initial begin
        ready_out = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            ready_out = rand_ready ? ($urandom_range(0, 9) < 7) : 1'b1;
        end
    end

    // Output monitor: scoreboard compare on fire, hold check under stall
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                checks++;
                if (!valid_out || data_out !== s_data || keep_out !== s_keep || last_out !== s_last) begin
                    failures++;
                    $display("FAIL stall_hold got v=%b d=%h k=%b l=%b need v=1 d=%h k=%b l=%b",
                             valid_out, data_out, keep_out, last_out, s_data, s_keep, s_last);
                end
            end
            if (valid_out && ready_out) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_beat got d=%h k=%b l=%b need no beat", data_out, keep_out, last_out);
                end else begin
                    e = exp_q.pop_front();
                    if (data_out !== e.data || keep_out !== e.keep || last_out !== e.last) begin
                        failures++;
                        $display("FAIL out_beat got d=%h k=%b l=%b need d=%h k=%b l=%b",
                                 data_out, keep_out, last_out, e.data, e.keep, e.last);
                    end
                end
            end
            stall_prev = valid_out && !ready_out;
            s_data = data_out;
            s_keep = keep_out;
            s_last = last_out;
        end
    end

    task automatic check1(input string nm, input logic [31:0] got, input logic [31:0] need);
        checks++;
        if (got !== need) begin
            failures++;
            $display("FAIL %s got=%h need=%h", nm, got, need);
        end
    endtask

    task automatic send_hdr(input logic [2:0] h, input logic [31:0] hdr);
        int k;
        valid_insert = 1'b1;
        data_insert = hdr;
        byte_insert_cnt = h;
        k = 0;
        @(negedge clk);
        while (!ready_insert && k < TMO) begin
            @(negedge clk);
            k++;
        end
        check1("hdr_handshake", 32'(ready_insert), 32'd1);
        @(posedge clk);
        #1;
        valid_insert = 1'b0;
        data_insert = $urandom;
        byte_insert_cnt = 3'($urandom);
    endtask

    task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        int n;
        valid_in = 1'b1;
        data_in = d;
        keep_in = k;
        last_in = l;
        n = 0;
        @(negedge clk);
        while (!ready_in && n < TMO) begin
            @(negedge clk);
            n++;
        end
        check1("beat_handshake", 32'(ready_in), 32'd1);
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        data_in = $urandom;
        keep_in = 4'($urandom);
        last_in = 1'b0;
    endtask

    task automatic gap(input bit rnd);
        if (rnd) begin
            repeat ($urandom_range(0, 1)) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic send_pkt(input logic [2:0] h, input logic [31:0] hdr, input int n,
                            input logic [3:0][31:0] d, input logic [3:0] kl, input bit rnd);
        gap(rnd);
        send_hdr(h, hdr);
        for (int i = 0; i < n; i++) begin
            gap(rnd);
            send_beat(d[i], (i == n - 1) ? kl : 4'hF, i == n - 1);
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < TMO) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk);
        #1;
        check1("drain_pending", 32'(exp_q.size()), 32'd0);
    endtask

    // Reference: header bytes then packet bytes as one byte queue, cut into beats
    task automatic model(input logic [2:0] h, input logic [31:0] hdr, input int n,
                         input logic [3:0][31:0] d, input int v);
        logic [7:0] q[$];
        exp_t       e;
        int         hc;
        hc = (int'(h) > 4) ? 4 : int'(h);
        for (int j = 0; j < hc; j++) q.push_back(hdr[8*(hc-1-j) +: 8]);
        for (int i = 0; i < n; i++) begin
            for (int b = 0; b < ((i == n - 1) ? v : 4); b++) q.push_back(d[i][31-8*b -: 8]);
        end
        while (q.size() > 0) begin
            e.data = '0;
            e.keep = '0;
            for (int b = 0; b < 4; b++) begin
                if (q.size() > 0) begin
                    e.data[31-8*b -: 8] = q.pop_front();
                    e.keep[3-b] = 1'b1;
                end
            end
            e.last = (q.size() == 0);
            exp_q.push_back(e);
        end
    endtask

    task automatic run_vec(input vec_t v);
        exp_t e;
        for (int i = 0; i < int'(v.nout); i++) begin
            e.data = v.dout[i];
            e.last = (i == int'(v.nout) - 1);
            e.keep = e.last ? v.kout : 4'hF;
            exp_q.push_back(e);
        end
        send_pkt(v.h, v.hdr, int'(v.nin), v.din, v.kin, 1'b0);
        drain();
    endtask

    initial begin
        logic [2:0]       h;
        logic [31:0]      hdr;
        logic [3:0][31:0] d;
        logic [3:0]       kl;
        int               n;
        int               v;
        exp_t             e;

        checks = 0;
        failures = 0;
        rand_ready = 1'b0;
        stall_prev = 1'b0;
        rst = 1'b1;
        valid_in = 1'b0;
        data_in = '0;
        keep_in = '0;
        last_in = 1'b0;
        valid_insert = 1'b0;
        data_insert = '0;
        byte_insert_cnt = '0;

        vecs[0] = '{h: 3'd1, hdr: 32'hAABBCCDD, nin: 3'd2,
                    din: {32'h0, 32'h0, 32'h55660000, 32'h11223344}, kin: 4'b1100,
                    nout: 3'd2, dout: {32'h0, 32'h0, 32'h44556600, 32'hDD112233}, kout: 4'b1110};
        vecs[1] = '{h: 3'd3, hdr: 32'h00AABBCC, nin: 3'd2,
                    din: {32'h0, 32'h0, 32'h55667700, 32'h11223344}, kin: 4'b1110,
                    nout: 3'd3, dout: {32'h0, 32'h66770000, 32'h22334455, 32'hAABBCC11}, kout: 4'b1100};
        vecs[2] = '{h: 3'd0, hdr: 32'h12345678, nin: 3'd3,
                    din: {32'h0, 32'h09000000, 32'h05060708, 32'h01020304}, kin: 4'b1000,
                    nout: 3'd3, dout: {32'h0, 32'h09000000, 32'h05060708, 32'h01020304}, kout: 4'b1000};
        vecs[3] = '{h: 3'd4, hdr: 32'hDEADBEEF, nin: 3'd1,
                    din: {32'h0, 32'h0, 32'h0, 32'h12345678}, kin: 4'b1111,
                    nout: 3'd2, dout: {32'h0, 32'h0, 32'h12345678, 32'hDEADBEEF}, kout: 4'b1111};
        vecs[4] = '{h: 3'd7, hdr: 32'h11223344, nin: 3'd1,
                    din: {32'h0, 32'h0, 32'h0, 32'hA5000000}, kin: 4'b1000,
                    nout: 3'd2, dout: {32'h0, 32'h0, 32'hA5000000, 32'h11223344}, kout: 4'b1000};
        vecs[5] = '{h: 3'd2, hdr: 32'h5555BEEF, nin: 3'd1,
                    din: {32'h0, 32'h0, 32'h0, 32'h12340000}, kin: 4'b1100,
                    nout: 3'd1, dout: {32'h0, 32'h0, 32'h0, 32'hBEEF1234}, kout: 4'b1111};

        // Reset values
        @(negedge clk);
        check1("rst_valid_out", 32'(valid_out), 32'd0);
        check1("rst_ready_in", 32'(ready_in), 32'd0);
        check1("rst_ready_insert", 32'(ready_insert), 32'd0);
        check1("rst_data_out", data_out, 32'd0);
        check1("rst_keep_out", 32'(keep_out), 32'd0);
        check1("rst_last_out", 32'(last_out), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check1("post_rst_ready_insert", 32'(ready_insert), 32'd1);
        @(posedge clk);
        #1;

        // Directed vector table
        for (int t = 0; t < 6; t++) run_vec(vecs[t]);

        // H=0 pass-through appears in the same cycle as the input beat
        e.data = 32'hCAFEF00D;
        e.keep = 4'hF;
        e.last = 1'b1;
        exp_q.push_back(e);
        send_hdr(3'd0, 32'h0);
        valid_in = 1'b1;
        data_in = 32'hCAFEF00D;
        keep_in = 4'hF;
        last_in = 1'b1;
        @(negedge clk);
        check1("h0_same_cycle_valid", 32'(valid_out), 32'd1);
        check1("h0_same_cycle_data", data_out, 32'hCAFEF00D);
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        last_in = 1'b0;
        drain();

        // Reset in the middle of an H=3 packet abandons it
        e.data = 32'hAABBCC11;
        e.keep = 4'hF;
        e.last = 1'b0;
        exp_q.push_back(e);
        send_hdr(3'd3, 32'h00AABBCC);
        send_beat(32'h11223344, 4'hF, 1'b0);
        valid_in = 1'b1;
        data_in = 32'h55667700;
        keep_in = 4'b1110;
        last_in = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        check1("midrst_valid_out", 32'(valid_out), 32'd0);
        check1("midrst_ready_insert", 32'(ready_insert), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        valid_in = 1'b0;
        last_in = 1'b0;
        @(negedge clk);
        check1("midrst_release_ready_insert", 32'(ready_insert), 32'd1);
        check1("midrst_valid_out_idle", 32'(valid_out), 32'd0);
        check1("midrst_consumed_beats", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
        run_vec(vecs[1]);

        // Randomized packets with output back-pressure and input gaps
        rand_ready = 1'b1;
        for (int p = 0; p < 1000; p++) begin
            h = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
            hdr = $urandom;
            n = $urandom_range(1, 4);
            v = $urandom_range(1, 4);
            kl = 4'(4'hF << (4 - v));
            for (int i = 0; i < 4; i++) d[i] = $urandom;
            model(h, hdr, n, d, v);
            send_pkt(h, hdr, n, d, kl, 1'b1);
        end
        drain();
        rand_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
